// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, syncs, strobes and blank-gated RGB.
// Latency: HPOS/VPOS are combinational (0); HBLK/VBLK/HSYN/VSYN/oRGB lag them by one ce_pix; strobes lag the wrap edge by one clk_sys.
// Backpressure: none; free-running raster that advances only on ce_pix and holds all state otherwise.
//
// Ports:
//   clk_sys      system clock
//   RESET_N      asynchronous active-low reset
//   ce_pix       pixel clock-enable
//   hshift       signed hsync offset in pixels (-8..+7), latched at frame start
//   vshift       signed vsync offset in lines  (-8..+7), latched at frame start
//   flip         mirror HPOS/VPOS inside the active area, latched at frame start
//   iRGB         pixel data for the current HPOS/VPOS
//   HPOS/VPOS    flip-mapped raster position
//   oRGB         registered pixel, forced to zero in blanking
//   HBLK/VBLK    registered horizontal/vertical blank
//   HSYN/VSYN    registered syncs, active level selected by SYNC_POL
//   line_start   one-clk_sys strobe after the ce_pix on which hcnt wraps
//   frame_start  one-clk_sys strobe after the ce_pix on which hcnt and vcnt both wrap
module video_timing_gen #(
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 22,
    parameter int CNT_W    = 9,
    parameter int RGB_W    = 12,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk_sys,
    input  logic             RESET_N,
    input  logic             ce_pix,
    input  logic [3:0]       hshift,
    input  logic [3:0]       vshift,
    input  logic             flip,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Two spare bits so a shifted sync window can be compared as a signed
    // quantity without any overflow concerns.
    localparam int SW = CNT_W + 2;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_MIRROR = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_MIRROR = CNT_W'(V_ACTIVE - 1);

    localparam logic signed [SW-1:0] HS_BEGIN = SW'(H_ACTIVE + H_FP);
    localparam logic signed [SW-1:0] HS_END   = SW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic signed [SW-1:0] VS_BEGIN = SW'(V_ACTIVE + V_FP);
    localparam logic signed [SW-1:0] VS_END   = SW'(V_ACTIVE + V_FP + V_SYNC);

    // Sync outputs drive the inverse of SYNC_POL while idle.
    localparam logic SYNC_IDLE = ~SYNC_POL;

    // ------------------------------------------------------------------
    // Raster counters and per-frame latched controls
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic signed [3:0] hsh_l;
    logic signed [3:0] vsh_l;
    logic              flip_l;

    logic h_wrap;
    logic v_wrap;
    logic frame_wrap;

    assign h_wrap     = (hcnt == H_LAST);
    assign v_wrap     = (vcnt == V_LAST);
    assign frame_wrap = h_wrap & v_wrap;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt   <= '0;
            vcnt   <= '0;
            hsh_l  <= '0;
            vsh_l  <= '0;
            flip_l <= 1'b0;
        end else if (ce_pix) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_wrap ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            // Controls sampled on the very edge that starts the new frame, so
            // a change coinciding with the wrap applies to the new frame.
            if (frame_wrap) begin
                hsh_l  <= hshift;
                vsh_l  <= vshift;
                flip_l <= flip;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic hb;
    logic vb;

    assign hb = (hcnt >= H_ACT_C);
    assign vb = (vcnt >= V_ACT_C);

    logic signed [SW-1:0] hcnt_s;
    logic signed [SW-1:0] vcnt_s;
    logic signed [SW-1:0] hsh_ext;
    logic signed [SW-1:0] vsh_ext;
    logic signed [SW-1:0] hs_lo;
    logic signed [SW-1:0] hs_hi;
    logic signed [SW-1:0] vs_lo;
    logic signed [SW-1:0] vs_hi;
    logic                 hs_act;
    logic                 vs_act;

    assign hcnt_s  = {2'b00, hcnt};
    assign vcnt_s  = {2'b00, vcnt};
    assign hsh_ext = {{(SW-4){hsh_l[3]}}, hsh_l};
    assign vsh_ext = {{(SW-4){vsh_l[3]}}, vsh_l};

    // Porches of at least 8 keep the shifted window inside blanking, so the
    // window never straddles the counter wrap.
    assign hs_lo  = HS_BEGIN + hsh_ext;
    assign hs_hi  = HS_END   + hsh_ext;
    assign vs_lo  = VS_BEGIN + vsh_ext;
    assign vs_hi  = VS_END   + vsh_ext;

    assign hs_act = (hcnt_s >= hs_lo) && (hcnt_s < hs_hi);
    assign vs_act = (vcnt_s >= vs_lo) && (vcnt_s < vs_hi);

    // Mirroring only inside the active area; blanking positions pass through
    // so downstream blank-region logic still sees the raw counter.
    assign HPOS = (flip_l && !hb) ? (H_MIRROR - hcnt) : hcnt;
    assign VPOS = (flip_l && !vb) ? (V_MIRROR - vcnt) : vcnt;

    // ------------------------------------------------------------------
    // Registered pixel stage: blanks, syncs and gated RGB stay aligned
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            HBLK <= 1'b1;
            VBLK <= 1'b1;
            HSYN <= SYNC_IDLE;
            VSYN <= SYNC_IDLE;
            oRGB <= '0;
        end else if (ce_pix) begin
            HBLK <= hb;
            VBLK <= vb;
            HSYN <= hs_act ^ SYNC_IDLE;
            VSYN <= vs_act ^ SYNC_IDLE;
            oRGB <= (hb || vb) ? '0 : iRGB;
        end
    end

    // ------------------------------------------------------------------
    // Strobes: updated every clk_sys so they are exactly one cycle wide
    // even when ce_pix is held high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= ce_pix & h_wrap;
            frame_start <= ce_pix & frame_wrap;
        end
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator. Successor to the fixed-count arcade HVGEN.
- Produces pixel/line counters, blanking, syncs, line/frame strobes and a blank-gated RGB output from a single system clock with pixel clock-enable.
- Adds runtime sync shift for screen centering, frame-latched flip, selectable sync polarity and arbitrary porch/active sizes.
- Sits between the game core (consumes HPOS/VPOS, supplies RGB) and arcade_rotate_fx / scaler.

Parameters:
- H_ACTIVE, 288, visible pixels per line
- H_FP, 24, front porch pixels (must be >= 8)
- H_SYNC, 32, hsync width pixels
- H_BP, 40, back porch pixels (must be >= 8)
- V_ACTIVE, 224, visible lines
- V_FP, 11, front porch lines (must be >= 8)
- V_SYNC, 7, vsync width lines
- V_BP, 22, back porch lines (must be >= 8)
- CNT_W, 9, counter/position width; must hold H_TOTAL-1 and V_TOTAL-1
- RGB_W, 12, pixel data width
- SYNC_POL, 0, 0 = sync active-low, 1 = active-high (applies to HS and VS)

Ports:
- clk_sys  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- ce_pix  in  1  pixel clock-enable; all timing state advances only when high
- hshift  in  4  signed hsync offset in pixels, -8..+7
- vshift  in  4  signed vsync offset in lines, -8..+7
- flip  in  1  mirror HPOS/VPOS in active area
- iRGB  in  RGB_W  pixel data for current HPOS/VPOS
- HPOS  out  CNT_W  horizontal position (flip-mapped)
- VPOS  out  CNT_W  vertical position (flip-mapped)
- oRGB  out  RGB_W  registered pixel, zero in blanking
- HBLK  out  1  horizontal blank
- VBLK  out  1  vertical blank
- HSYN  out  1  horizontal sync, polarity per SYNC_POL
- VSYN  out  1  vertical sync, polarity per SYNC_POL
- line_start  out  1  one-clk_sys strobe when hcnt wraps to 0
- frame_start  out  1  one-clk_sys strobe when hcnt and vcnt both wrap to 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1. On ce_pix, hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt wraps at V_TOTAL-1. No state change when ce_pix = 0.
- Frame latch: on the ce_pix where both counters wrap to 0, hshift, vshift and flip are latched. Mid-frame changes have no effect until the next frame.
- Decode (combinational from current hcnt/vcnt and latched values):
  - hb = hcnt >= H_ACTIVE; vb = vcnt >= V_ACTIVE.
  - hs_act when H_ACTIVE+H_FP+hsh <= hcnt < H_ACTIVE+H_FP+H_SYNC+hsh.
  - vs_act analogous on vcnt using vsh.
  - Shift is signed-extended before the add. The porch >= 8 constraint keeps the window inside blanking with no wrap.
- HPOS = flip_l & !hb ? H_ACTIVE-1-hcnt : hcnt. VPOS is analogous with V_ACTIVE/vb. Both are combinational from the counters, latency 0.
- Registered stage, on ce_pix only:
  - HBLK <= hb; VBLK <= vb.
  - HSYN <= hs_act ^ !SYNC_POL; VSYN <= vs_act ^ !SYNC_POL.
  - oRGB <= (hb|vb) ? 0 : iRGB.
  - Result: all five outputs lag HPOS/VPOS by exactly one ce_pix and are mutually aligned.
- Strobes: line_start = 1 for exactly the clk_sys cycle in which ce_pix=1 and hcnt = H_TOTAL-1 (the wrap). frame_start is the same with vcnt = V_TOTAL-1 in addition. They are registered, so they are high in the clk_sys cycle after that ce_pix edge.
- Reset (async, RESET_N = 0), all held until release:
  - hcnt = vcnt = 0; latched shifts and flip = 0.
  - HBLK = VBLK = 1; HSYN = VSYN = inactive level (SYNC_POL ? 0 : 1).
  - oRGB = 0; strobes = 0.
  - Mid-frame reset aborts the frame. The first ce_pix after release latches nothing; counting starts from 0,0.
- Boundaries:
  - ce_pix held high every clk_sys cycle is legal.
  - Shift of -8 with a porch of exactly 8 places sync starting at the first blank pixel/line.
  - Simultaneous frame wrap and shift change: new values apply to the new frame.

Test Plan:
- Reset: assert RESET_N=0 mid-line → HBLK=VBLK=1, HSYN=VSYN=1 (SYNC_POL=0), oRGB=0, HPOS=VPOS=0. On release, first frame_start arrives after exactly H_TOTAL*V_TOTAL ce_pix pulses.
- Line timing (H 8/8/3/8, V 4/8/2/8, ce every clk): HBLK falls one ce after hcnt=0 and rises one ce after hcnt=8. HSYN low for 3 ce, starting one ce after hcnt=16. line_start period = 27 ce.
- Shift: hshift=-3 written mid-frame → no change that frame; next frame HSYN starts one ce after hcnt=13. vshift=+7 → VSYN starts one ce after the line with vcnt=19.
- Flip: flip=1 mid-frame → effective from next frame_start. With H_ACTIVE=288: HPOS=287 at hcnt=0, HPOS=0 at hcnt=287, HPOS=hcnt in blanking.
- Gating: ce_pix every 4th clk → counters, outputs and oRGB frozen between enables. Strobes are one clk_sys wide. iRGB=0xFFF during blank gives oRGB=0; during active, iRGB appears one ce later.
- Polarity: SYNC_POL=1 build → HSYN/VSYN idle 0 after reset, pulses high with identical timing.
